// File: rtl/axi_lite_beat_master.sv
// ---------------------------------------------------------------------------
// axi_lite_beat_master
//
// Moves one AXI4-Lite beat at a time on behalf of a cache block engine.
// While i_start_read or i_start_write is held high, each beat's address
// (and write data) is taken from i_addr / i_data. Every completed beat is
// reported with a single-cycle o_done pulse. An external beat counter
// raises i_count_done to stop further launches. Reads win over writes when
// both starts are high. All outputs come straight from flops.
//
// Ports
//   i_clk, i_arst      : clock (rising edge), synchronous active-low reset
//   i_start_read       : block read requested (held for whole block)
//   i_start_write      : block write requested (held for whole block)
//   i_count_done       : beat counter exhausted, launch no more beats
//   i_addr, i_data     : address / write data of the current beat
//   o_done             : one-cycle pulse per completed beat
//   o_data             : data of the most recent read beat
//   o_error            : sticky flag, a nonzero RRESP or BRESP was seen
//   AR/R/AW/W/B        : AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axi_lite_beat_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                        i_clk,
    input  logic                        i_arst,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic                        i_count_done,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   i_data,
    output logic                        o_done,
    output logic [AXI_DATA_WIDTH-1:0]   o_data,
    output logic                        o_error,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                  i_rresp,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t                      state, state_n;
    logic                        done_n, error_n;
    logic [AXI_DATA_WIDTH-1:0]   data_n;
    logic                        arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_n, awaddr_n;
    logic [AXI_DATA_WIDTH-1:0]   wdata_n;
    logic [STRB_WIDTH-1:0]       wstrb_n;
    logic                        aw_finished, w_finished;

    // State and every output are registered here; reset wins over all else.
    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state     <= IDLE;
            o_done    <= 1'b0;
            o_data    <= '0;
            o_error   <= 1'b0;
            o_arvalid <= 1'b0;
            o_araddr  <= '0;
            o_rready  <= 1'b0;
            o_awvalid <= 1'b0;
            o_awaddr  <= '0;
            o_wvalid  <= 1'b0;
            o_wdata   <= '0;
            o_wstrb   <= '0;
            o_bready  <= 1'b0;
        end else begin
            state     <= state_n;
            o_done    <= done_n;
            o_data    <= data_n;
            o_error   <= error_n;
            o_arvalid <= arvalid_n;
            o_araddr  <= araddr_n;
            o_rready  <= rready_n;
            o_awvalid <= awvalid_n;
            o_awaddr  <= awaddr_n;
            o_wvalid  <= wvalid_n;
            o_wdata   <= wdata_n;
            o_wstrb   <= wstrb_n;
            o_bready  <= bready_n;
        end
    end

    // Next-state and next-output logic. Everything holds by default and
    // o_done defaults low, so the pulse lasts exactly one cycle.
    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        data_n    = o_data;
        error_n   = o_error;
        arvalid_n = o_arvalid;
        araddr_n  = o_araddr;
        rready_n  = o_rready;
        awvalid_n = o_awvalid;
        awaddr_n  = o_awaddr;
        wvalid_n  = o_wvalid;
        wdata_n   = o_wdata;
        wstrb_n   = o_wstrb;
        bready_n  = o_bready;

        // A write channel counts as finished once its VALID is already low
        // or it handshakes this cycle, so AW and W may complete in any order.
        aw_finished = !o_awvalid || i_awready;
        w_finished  = !o_wvalid || i_wready;

        unique case (state)
            IDLE: begin
                if (!i_start_read && !i_start_write) begin
                    error_n = 1'b0;
                end
                // Holding off while o_done is high gives the external beat
                // counter one cycle to update i_count_done.
                if (!o_done && !i_count_done) begin
                    if (i_start_read) begin
                        araddr_n  = i_addr;
                        arvalid_n = 1'b1;
                        state_n   = RD_ADDR;
                    end else if (i_start_write) begin
                        awaddr_n  = i_addr;
                        wdata_n   = i_data;
                        wstrb_n   = {STRB_WIDTH{1'b1}};
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        state_n   = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (o_arvalid && i_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (i_rvalid && o_rready) begin
                    data_n   = i_rdata;
                    rready_n = 1'b0;
                    done_n   = 1'b1;
                    if (i_rresp != 2'b00) begin
                        error_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            WR_REQ: begin
                if (o_awvalid && i_awready) begin
                    awvalid_n = 1'b0;
                end
                if (o_wvalid && i_wready) begin
                    wvalid_n = 1'b0;
                end
                if (aw_finished && w_finished) begin
                    bready_n = 1'b1;
                    state_n  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid && o_bready) begin
                    bready_n = 1'b0;
                    done_n   = 1'b1;
                    if (i_bresp != 2'b00) begin
                        error_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_beat_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_beat_master
//
// Self-checking bench for axi_lite_beat_master. The bench plays the AXI
// slave and the beat counter. Each beat is described by what should happen
// on the bus (address, data, response, stall lengths), and the bench checks
// the DUT against that description one cycle at a time. Inputs are driven
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_beat_master;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int SW = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_start_read, i_start_write, i_count_done;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          o_done, o_error;
    logic [DW-1:0] o_data;
    logic          o_arvalid, i_arready;
    logic [AW-1:0] o_araddr;
    logic          i_rvalid, o_rready;
    logic [DW-1:0] i_rdata;
    logic [1:0]    i_rresp;
    logic          o_awvalid, i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid, i_wready;
    logic [DW-1:0] o_wdata;
    logic [SW-1:0] o_wstrb;
    logic          i_bvalid, o_bready;
    logic [1:0]    i_bresp;

    int   checks = 0;
    int   errors = 0;
    int   ar_count = 0;
    int   aw_count = 0;
    logic err_model = 1'b0;

    axi_lite_beat_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_count_done(i_count_done), .i_addr(i_addr), .i_data(i_data),
        .o_done(o_done), .o_data(o_data), .o_error(o_error),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    // One read beat: launch, AR stall of ar_dly cycles, R stall of r_dly
    // cycles, then the done pulse and its trailing idle cycle.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] rdata,
                           input logic [1:0] rresp, input int ar_dly, input int r_dly,
                           input bit drop_mid);
        int n = 0;
        i_addr = addr;
        i_start_read = 1'b1;
        @(negedge i_clk);
        while (!o_arvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_arvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_launch arvalid=%b expected 1", o_arvalid);
            return;
        end
        if (drop_mid) i_start_read = 1'b0;
        i_addr = ~addr;
        checks++;
        if (o_araddr !== addr) begin
            errors++;
            $display("[TB] FAIL rd_araddr got %h expected %h", o_araddr, addr);
        end
        checks++;
        if (o_awvalid !== 1'b0 || o_wvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_no_write awvalid=%b wvalid=%b expected 0 0", o_awvalid, o_wvalid);
        end
        for (int k = 0; k < ar_dly; k++) begin
            i_arready = 1'b0;
            @(negedge i_clk);
            checks++;
            if (o_arvalid !== 1'b1 || o_araddr !== addr) begin
                errors++;
                $display("[TB] FAIL ar_hold arvalid=%b araddr=%h expected 1 %h", o_arvalid, o_araddr, addr);
            end
        end
        i_arready = 1'b1;
        @(negedge i_clk);
        i_arready = 1'b0;
        ar_count++;
        checks++;
        if (o_arvalid !== 1'b0 || o_rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ar_handshake arvalid=%b rready=%b expected 0 1", o_arvalid, o_rready);
        end
        for (int k = 0; k < r_dly; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_rready !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL r_wait rready=%b done=%b expected 1 0", o_rready, o_done);
            end
        end
        i_rvalid = 1'b1;
        i_rdata = rdata;
        i_rresp = rresp;
        @(negedge i_clk);
        i_rvalid = 1'b0;
        i_rdata = $urandom;
        i_rresp = 2'b00;
        if (rresp != 2'b00) err_model = 1'b1;
        checks++;
        if (o_done !== 1'b1 || o_rready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_done done=%b rready=%b expected 1 0", o_done, o_rready);
        end
        checks++;
        if (o_data !== rdata) begin
            errors++;
            $display("[TB] FAIL rd_data got %h expected %h", o_data, rdata);
        end
        checks++;
        if (o_error !== err_model) begin
            errors++;
            $display("[TB] FAIL rd_error got %b expected %b", o_error, err_model);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_arvalid !== 1'b0 || o_awvalid !== 1'b0 || o_data !== rdata) begin
            errors++;
            $display("[TB] FAIL rd_after done=%b arvalid=%b awvalid=%b data=%h expected 0 0 0 %h",
                     o_done, o_arvalid, o_awvalid, o_data, rdata);
        end
    endtask

    // One write beat: AW and W handshakes after independent stalls, then a
    // B stall of b_dly cycles, the done pulse and its trailing idle cycle.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [1:0] bresp, input int aw_dly, input int w_dly,
                            input int b_dly);
        int   n = 0;
        int   t = 0;
        logic awd = 1'b0;
        logic wd = 1'b0;
        i_addr = addr;
        i_data = data;
        i_start_read = 1'b0;
        i_start_write = 1'b1;
        @(negedge i_clk);
        while (!o_awvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_awvalid !== 1'b1 || o_wvalid !== 1'b1 || o_arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_launch awvalid=%b wvalid=%b arvalid=%b expected 1 1 0",
                     o_awvalid, o_wvalid, o_arvalid);
            return;
        end
        i_addr = rand_addr();
        i_data = ~data;
        checks++;
        if (o_awaddr !== addr || o_wdata !== data || o_wstrb !== {SW{1'b1}}) begin
            errors++;
            $display("[TB] FAIL wr_fields awaddr=%h wdata=%h wstrb=%h expected %h %h %h",
                     o_awaddr, o_wdata, o_wstrb, addr, data, {SW{1'b1}});
        end
        while (!(awd && wd) && t < 12) begin
            i_awready = !awd && (t >= aw_dly);
            i_wready  = !wd && (t >= w_dly);
            @(negedge i_clk);
            if (i_awready) begin
                awd = 1'b1;
                aw_count++;
            end
            if (i_wready) wd = 1'b1;
            checks++;
            if (o_awvalid !== !awd || o_wvalid !== !wd || o_bready !== (awd && wd)) begin
                errors++;
                $display("[TB] FAIL wr_req t=%0d awvalid=%b wvalid=%b bready=%b expected %b %b %b",
                         t, o_awvalid, o_wvalid, o_bready, !awd, !wd, awd && wd);
            end
            checks++;
            if ((o_awvalid && o_awaddr !== addr) || (o_wvalid && o_wdata !== data)) begin
                errors++;
                $display("[TB] FAIL wr_stable awaddr=%h wdata=%h expected %h %h",
                         o_awaddr, o_wdata, addr, data);
            end
            t++;
        end
        i_awready = 1'b0;
        i_wready = 1'b0;
        for (int k = 0; k < b_dly; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_bready !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b_wait bready=%b done=%b expected 1 0", o_bready, o_done);
            end
        end
        i_bvalid = 1'b1;
        i_bresp = bresp;
        @(negedge i_clk);
        i_bvalid = 1'b0;
        i_bresp = 2'b00;
        if (bresp != 2'b00) err_model = 1'b1;
        checks++;
        if (o_done !== 1'b1 || o_bready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_done done=%b bready=%b expected 1 0", o_done, o_bready);
        end
        checks++;
        if (o_error !== err_model) begin
            errors++;
            $display("[TB] FAIL wr_error got %b expected %b", o_error, err_model);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_awvalid !== 1'b0 || o_arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_after done=%b awvalid=%b arvalid=%b expected 0 0 0",
                     o_done, o_awvalid, o_arvalid);
        end
    endtask

    // Both starts dropped while idle: error must clear and nothing launches.
    task automatic release_starts();
        i_start_read = 1'b0;
        i_start_write = 1'b0;
        @(negedge i_clk);
        err_model = 1'b0;
        checks++;
        if (o_error !== 1'b0 || o_arvalid !== 1'b0 || o_awvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release error=%b arvalid=%b awvalid=%b expected 0 0 0",
                     o_error, o_arvalid, o_awvalid);
        end
    endtask

    task automatic test_reset();
        i_arst = 1'b0;
        i_start_read = 1'b0; i_start_write = 1'b0; i_count_done = 1'b0;
        i_addr = '0; i_data = '0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_done, o_data, o_error, o_arvalid, o_araddr, o_rready, o_awvalid, o_awaddr,
             o_wvalid, o_wdata, o_wstrb, o_bready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 0",
                     {o_done, o_data, o_error, o_arvalid, o_araddr, o_rready, o_awvalid,
                      o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready});
        end
        i_arst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_arvalid !== 1'b0 || o_awvalid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle arvalid=%b awvalid=%b done=%b expected 0 0 0",
                     o_arvalid, o_awvalid, o_done);
        end
    endtask

    task automatic test_read_basic();
        do_read(rand_addr(), 32'hDEADBEEF, 2'b00, 0, 0, 1'b0);
        release_starts();
    endtask

    task automatic test_write_stall();
        do_write(rand_addr(), $urandom, 2'b00, 2, 3, 1);
        release_starts();
    endtask

    task automatic test_priority();
        i_start_write = 1'b1;
        do_read(rand_addr(), $urandom, 2'b00, 1, 1, 1'b0);
        release_starts();
    endtask

    task automatic test_block_read();
        int            beats = 0;
        int            stray = 0;
        logic [AW-1:0] base = rand_addr();
        ar_count = 0;
        i_count_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_read(base + AW'(4 * i), $urandom, 2'b00, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
            beats++;
            i_count_done = (beats == 16);
        end
        repeat (10) begin
            @(negedge i_clk);
            if (o_arvalid) stray++;
        end
        checks++;
        if (ar_count != 16 || stray != 0) begin
            errors++;
            $display("[TB] FAIL block_read ar_handshakes=%0d stray_arvalid_cycles=%0d expected 16 0",
                     ar_count, stray);
        end
        i_count_done = 1'b0;
        release_starts();
    endtask

    task automatic test_error_sticky();
        do_write(rand_addr(), $urandom, 2'b10, 0, 0, 0);
        do_write(rand_addr(), $urandom, 2'b00, 1, 0, 2);
        release_starts();
        do_read(rand_addr(), $urandom, 2'b11, 0, 1, 1'b0);
        release_starts();
    endtask

    task automatic test_drop_mid();
        int stray = 0;
        do_read(rand_addr(), $urandom, 2'b00, 2, 1, 1'b1);
        repeat (4) begin
            @(negedge i_clk);
            if (o_arvalid || o_awvalid || o_done) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL drop_mid stray_activity_cycles=%0d expected 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        i_addr = rand_addr();
        i_start_read = 1'b1;
        i_arready = 1'b0;
        @(negedge i_clk);
        while (!o_arvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_arvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_launch arvalid=%b expected 1", o_arvalid);
        end
        i_arst = 1'b0;
        i_arready = 1'b1;
        @(negedge i_clk);
        i_arst = 1'b1;
        i_arready = 1'b0;
        err_model = 1'b0;
        checks++;
        if ({o_done, o_data, o_error, o_arvalid, o_araddr, o_rready, o_awvalid, o_awaddr,
             o_wvalid, o_wdata, o_wstrb, o_bready} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs got %h expected 0",
                     {o_done, o_data, o_error, o_arvalid, o_araddr, o_rready, o_awvalid,
                      o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready});
        end
        do_read(rand_addr(), $urandom, 2'b00, 0, 2, 1'b0);
        release_starts();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                i_start_write = 1'($urandom_range(0, 1));
                do_read(rand_addr(), $urandom, resp, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            end else begin
                do_write(rand_addr(), $urandom, resp, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) release_starts();
        end
        release_starts();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_stall();
        test_priority();
        test_block_read();
        test_error_sticky();
        test_drop_mid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_beat_master.md
AXI_LITE_BEAT_MASTER -- requirements
Module: axi_lite_beat_master

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32: width of one AXI beat.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64: width of AXI address.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_arst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start_read  input  1  cache requests block read, held high for whole block.
REQ-006 SHALL have port i_start_write  input  1  cache requests block write, held high for whole block.
REQ-007 SHALL have port i_count_done  input  1  beat counter reached limit; no further beats.
REQ-008 SHALL have port i_addr  input  AXI_ADDR_WIDTH  current beat address.
REQ-009 SHALL have port i_data  input  AXI_DATA_WIDTH  current write beat data.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse per completed beat.
REQ-011 SHALL have port o_data  output  AXI_DATA_WIDTH  last read beat data.
REQ-012 SHALL have port o_error  output  1  sticky: nonzero RRESP/BRESP seen.
REQ-013 SHALL have ports o_arvalid out 1, i_arready in 1, o_araddr out AXI_ADDR_WIDTH: AR channel.
REQ-014 SHALL have ports i_rvalid in 1, o_rready out 1, i_rdata in AXI_DATA_WIDTH, i_rresp in 2: R channel.
REQ-015 SHALL have ports o_awvalid out 1, i_awready in 1, o_awaddr out AXI_ADDR_WIDTH: AW channel.
REQ-016 SHALL have ports o_wvalid out 1, i_wready in 1, o_wdata out AXI_DATA_WIDTH, o_wstrb out AXI_DATA_WIDTH/8: W channel.
REQ-017 SHALL have ports i_bvalid in 1, o_bready out 1, i_bresp in 2: B channel.

Function
REQ-018 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; all outputs registered.
REQ-019 IDLE SHALL launch only when o_done=0 and i_count_done=0; i_start_read has priority over i_start_write.
REQ-020 Read launch: o_araddr<=i_addr, o_arvalid<=1, go RD_ADDR.
REQ-021 RD_ADDR: o_arvalid held until arvalid&arready; then o_arvalid<=0, o_rready<=1, go RD_DATA.
REQ-022 RD_DATA: on rvalid&rready, o_data<=i_rdata, o_rready<=0, o_done<=1 next cycle, go IDLE.
REQ-023 Write launch: o_awaddr<=i_addr, o_wdata<=i_data, o_wstrb<=all ones, o_awvalid<=1, o_wvalid<=1, go WR_REQ.
REQ-024 WR_REQ: o_awvalid and o_wvalid each drop independently on own handshake; both done (same or different cycles) -> o_bready<=1, go WR_RESP.
REQ-025 WR_RESP: on bvalid&bready, o_bready<=0, o_done<=1 next cycle, go IDLE.
REQ-026 o_done SHALL be high exactly one cycle per beat; cycle it is high IDLE SHALL not launch (counter settles).
REQ-027 VALID signals SHALL never drop before handshake; address/data stable while VALID high.
REQ-028 Start deasserted mid-beat: beat completes normally, o_done still pulses; no new launch.
REQ-029 o_error SET when handshaked i_rresp or i_bresp != 2'b00; cleared in IDLE when both starts low.
REQ-030 o_data SHALL hold value until next read handshake.

Reset
REQ-031 i_arst=0 at clock edge SHALL force IDLE and all outputs to 0, including mid-handshake.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Read, arready/rvalid immediate, rdata=0xDEADBEEF -> o_done pulses once, o_data=0xDEADBEEF, o_error=0.
REQ-034 Write, awready 1 cycle before wready (3-cycle stall) -> each VALID drops on own handshake; bready only after both; one o_done.
REQ-035 Both starts high, i_count_done=0 -> read beat issued, no AW/W activity.
REQ-036 16-beat read with counter model, i_count_done after 16th -> exactly 16 AR handshakes, no 17th.
REQ-037 bresp=2'b10 -> o_error=1 after beat, stays 1 until starts low in IDLE.
REQ-038 Reset asserted while o_arvalid=1 -> next cycle all outputs 0, state IDLE, clean restart.
